me_curr_feeder: RTL and testbench

Transmit side of the current-block load path of the motion-estimation PE array. On `start` it reads two current blocks (bank A, then bank B) from the current-frame word buffer. It streams them as pixel pairs into the head of a PE shift chain of `NPE` PEs, driving `out_curr_enable` and `out_cb_select`. Order is farthest-PE-first, so after 2·`NPE` enable cycles every PE holds its own pixels in both banks. A stall input (`hold`) freezes the stream without losing data.

---
 rtl/me_curr_feeder_if.sv | 32 +++
 rtl/me_curr_feeder.sv | 137 +++++++++++++
 tb/tb_me_curr_feeder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/me_curr_feeder_if.sv
// Bus bundle between the current-block feeder, the current-frame word buffer and the PE chain head.
// The master side drives requests and buffer read data; the slave side is the feeder itself.
interface me_curr_feeder_if #(
    parameter int PIXEL = 8,
    parameter int AW    = 10
);
    logic                 start;
    logic [AW-1:0]        base_a;
    logic [AW-1:0]        base_b;
    logic                 hold;
    logic                 mem_rd_en;
    logic [AW-1:0]        mem_addr;
    logic [2*PIXEL-1:0]   mem_rdata;
    logic [PIXEL-1:0]     out_curr1;
    logic [PIXEL-1:0]     out_curr2;
    logic                 out_curr_enable;
    logic                 out_cb_select;
    logic                 busy;
    logic                 done;

    modport master (
        output start, base_a, base_b, hold, mem_rdata,
        input  mem_rd_en, mem_addr, out_curr1, out_curr2,
               out_curr_enable, out_cb_select, busy, done
    );

    modport slave (
        input  start, base_a, base_b, hold, mem_rdata,
        output mem_rd_en, mem_addr, out_curr1, out_curr2,
               out_curr_enable, out_cb_select, busy, done
    );
endinterface

// File: rtl/me_curr_feeder.sv
// Streams bank A then bank B current-block pixel pairs, farthest PE first, into the PE shift chain.
// A one-entry skid absorbs the read that returns while the array is stalled.
module me_curr_feeder #(
    parameter int PIXEL = 8,
    parameter int NPE   = 16,
    parameter int AW    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    me_curr_feeder_if.slave     bus
);
    localparam int KW = (NPE > 1) ? $clog2(NPE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NPE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN_A,
        S_RUN_B,
        S_DRAIN
    } state_t;

    state_t               state_q;
    logic [KW-1:0]        k_q;
    logic [AW-1:0]        base_a_q;
    logic [AW-1:0]        base_b_q;
    logic [AW-1:0]        addr_q;
    logic                 pend_q;
    logic                 pend_tag_q;
    logic                 skid_full_q;
    logic                 skid_tag_q;
    logic [2*PIXEL-1:0]   skid_data_q;
    logic                 done_q;

    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic                 emit_skid;
    logic                 emit_direct;
    logic                 emit;
    logic [2*PIXEL-1:0]   emit_word;
    logic                 emit_tag;

    always_comb begin
        rd_en       = ((state_q == S_RUN_A) || (state_q == S_RUN_B)) && !bus.hold;
        rd_addr     = ((state_q == S_RUN_A) ? base_a_q : base_b_q) + AW'(k_q);
        // A full skid always drains before fresh data; the two never coexist.
        emit_skid   = skid_full_q && !bus.hold;
        emit_direct = pend_q && !bus.hold && !skid_full_q;
        emit        = emit_skid || emit_direct;
        emit_word   = '0;
        emit_tag    = 1'b0;
        if (emit_skid) begin
            emit_word = skid_data_q;
            emit_tag  = skid_tag_q;
        end else if (emit_direct) begin
            emit_word = bus.mem_rdata;
            emit_tag  = pend_tag_q;
        end
    end

    assign bus.mem_rd_en       = rd_en;
    assign bus.mem_addr        = rd_en ? rd_addr : addr_q;
    assign bus.out_curr_enable = emit;
    assign bus.out_curr1       = emit_word[PIXEL-1:0];
    assign bus.out_curr2       = emit_word[2*PIXEL-1:PIXEL];
    assign bus.out_cb_select   = emit_tag;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_tag_q  <= 1'b0;
            skid_full_q <= 1'b0;
            skid_tag_q  <= 1'b0;
            skid_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= rd_en;
            if (rd_en) begin
                pend_tag_q <= (state_q == S_RUN_A);
                addr_q     <= rd_addr;
            end

            if (pend_q && bus.hold) begin
                skid_full_q <= 1'b1;
                skid_data_q <= bus.mem_rdata;
                skid_tag_q  <= pend_tag_q;
            end else if (emit_skid) begin
                skid_full_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        base_a_q <= bus.base_a;
                        base_b_q <= bus.base_b;
                        k_q      <= K_LAST;
                        state_q  <= S_RUN_A;
                    end
                end
                S_RUN_A: begin
                    if (!bus.hold) begin
                        if (k_q == '0) begin
                            k_q     <= K_LAST;
                            state_q <= S_RUN_B;
                        end else begin
                            k_q <= k_q - KW'(1);
                        end
                    end
                end
                S_RUN_B: begin
                    if (!bus.hold) begin
                        if (k_q == '0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            k_q <= k_q - KW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Only the final datum is outstanding here, so its emission ends the run.
                    if (emit) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_curr_feeder.sv
// Directed, table-driven bench for me_curr_feeder with NPE=4, AW=10, PIXEL=8.
// Buffer word at address a is {a[7:0]+8'h40, a[7:0]}.
module tb_me_curr_feeder;
    localparam int PIXEL = 8;
    localparam int NPE   = 4;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    me_curr_feeder_if #(.PIXEL(PIXEL), .AW(AW)) bus ();

    me_curr_feeder #(.PIXEL(PIXEL), .NPE(NPE), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [15:0] word_at(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo + 8'h40, lo};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= word_at(bus.mem_addr);
    end

    typedef struct {
        logic          start;
        logic          hold;
        logic          rd;
        logic [AW-1:0] addr;
        logic          en;
        logic [7:0]    c1;
        logic          sel;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic st, input logic h, input logic rd, input logic [AW-1:0] a,
                               input logic en, input logic [7:0] c1, input logic sel,
                               input logic busy, input logic done);
        vec_t r;
        r.start = st; r.hold = h; r.rd = rd; r.addr = a; r.en = en;
        r.c1 = c1; r.sel = sel; r.busy = busy; r.done = done;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_overlap(input string tag);
        chk({tag, " skid_overlap"}, 32'(dut.pend_q && dut.skid_full_q), 32'd0);
    endtask

    task automatic run_tbl(input int lo, input int hi, input string tag);
        logic [7:0] c2_exp;
        string      nm;
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk);
            #1;
            bus.start = tbl[i].start;
            bus.hold  = tbl[i].hold;
            #1;
            nm = $sformatf("%s c%0d", tag, i - lo);
            c2_exp = tbl[i].en ? (tbl[i].c1 + 8'h40) : 8'h00;
            $display("%s rd=%0b addr=%h en=%0b pair=%h/%h sel=%0b busy=%0b done=%0b", nm,
                     bus.mem_rd_en, bus.mem_addr, bus.out_curr_enable, bus.out_curr1,
                     bus.out_curr2, bus.out_cb_select, bus.busy, bus.done);
            chk({nm, " mem_rd_en"}, 32'(bus.mem_rd_en), 32'(tbl[i].rd));
            if (tbl[i].rd) chk({nm, " mem_addr"}, 32'(bus.mem_addr), 32'(tbl[i].addr));
            chk({nm, " enable"}, 32'(bus.out_curr_enable), 32'(tbl[i].en));
            chk({nm, " curr1"}, 32'(bus.out_curr1), 32'(tbl[i].c1));
            chk({nm, " curr2"}, 32'(bus.out_curr2), 32'(c2_exp));
            chk({nm, " cb_select"}, 32'(bus.out_cb_select), 32'(tbl[i].sel));
            chk({nm, " busy"}, 32'(bus.busy), 32'(tbl[i].busy));
            chk({nm, " done"}, 32'(bus.done), 32'(tbl[i].done));
            check_overlap(nm);
        end
        #1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t r;
        bus.start  = 1'b0;
        bus.hold   = 1'b0;
        bus.base_a = 10'h010;
        bus.base_b = 10'h020;

        // Nominal run: records 0..11
        tbl.push_back(v(1, 0, 0, 10'h000, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 10'h013, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h012, 1, 8'h13, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h011, 1, 8'h12, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h010, 1, 8'h11, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h023, 1, 8'h10, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h022, 1, 8'h23, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h021, 1, 8'h22, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h020, 1, 8'h21, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 10'h000, 1, 8'h20, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 10'h000, 0, 8'h00, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 10'h000, 0, 8'h00, 0, 0, 0));
        // Stall in cycles 3..5: records 12..26
        tbl.push_back(v(1, 0, 0, 10'h000, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 10'h013, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h012, 1, 8'h13, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 10'h000, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 10'h000, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 10'h000, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h011, 1, 8'h12, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h010, 1, 8'h11, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h023, 1, 8'h10, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h022, 1, 8'h23, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h021, 1, 8'h22, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'h020, 1, 8'h21, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 10'h000, 1, 8'h20, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 10'h000, 0, 8'h00, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 10'h000, 0, 8'h00, 0, 0, 0));
        // Ignored starts in cycles 4 and 7, start with done in cycle 10: records 27..48
        tbl.push_back(tbl[0]);
        for (int i = 1; i <= 10; i++) begin
            r = tbl[i];
            r.start = (i == 4 || i == 7 || i == 10);
            tbl.push_back(r);
        end
        for (int i = 1; i <= 11; i++) tbl.push_back(tbl[i]);

        // Reset state
        step();
        step();
        #1;
        chk("reset mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset enable", 32'(bus.out_curr_enable), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        step();
        rst_n = 1'b1;

        run_tbl(0, 11, "nominal");
        run_tbl(12, 26, "stall");
        run_tbl(27, 48, "restart");

        // Address wrap of bank A
        bus.base_a = 10'h3FE;
        bus.base_b = 10'h100;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        #1;
        chk("wrap c1 addr", 32'(bus.mem_addr), 32'h001);
        step(); #1;
        chk("wrap c2 addr", 32'(bus.mem_addr), 32'h000);
        chk("wrap c2 curr1", 32'(bus.out_curr1), 32'h01);
        chk("wrap c2 curr2", 32'(bus.out_curr2), 32'h41);
        step(); #1;
        chk("wrap c3 addr", 32'(bus.mem_addr), 32'h3FF);
        chk("wrap c3 curr1", 32'(bus.out_curr1), 32'h00);
        step(); #1;
        chk("wrap c4 addr", 32'(bus.mem_addr), 32'h3FE);
        chk("wrap c4 curr1", 32'(bus.out_curr1), 32'hFF);
        for (int c = 5; c <= 10; c++) step();
        #1;
        chk("wrap c10 done", 32'(bus.done), 32'd1);
        $display("wrap run complete");

        // Reset in cycle 5 of a run
        bus.base_a = 10'h010;
        bus.base_b = 10'h020;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("midrst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("midrst enable", 32'(bus.out_curr_enable), 32'd0);
        chk("midrst curr1", 32'(bus.out_curr1), 32'd0);
        chk("midrst curr2", 32'(bus.out_curr2), 32'd0);
        chk("midrst cb_select", 32'(bus.out_cb_select), 32'd0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(); #1;
            chk($sformatf("postrst c%0d enable", c), 32'(bus.out_curr_enable), 32'd0);
            chk($sformatf("postrst c%0d rd_en", c), 32'(bus.mem_rd_en), 32'd0);
        end
        $display("mid-run reset complete");
        run_tbl(0, 11, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
